// File: rtl/posit_pack_pipe_if.sv
// Valid/ready stream bundle for the posit packer: decoded fields in, encoded posit out.
interface posit_pack_pipe_if #(
  parameter int unsigned BITS   = 32,
  parameter int unsigned ES     = 3,
  parameter int unsigned FRAC_W = 32,
  parameter int unsigned REG_W  = $clog2(BITS) + 2
);
  localparam int unsigned ExpW = (ES > 0) ? ES : 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [REG_W-1:0]  in_regime;
  logic [ExpW-1:0]   in_exp;
  logic [FRAC_W-1:0] in_frac;
  logic              in_sticky;
  logic              in_zero;
  logic              in_nar;
  logic              out_valid;
  logic              out_ready;
  logic [BITS-1:0]   out_posit;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_sign,
    input  in_regime,
    input  in_exp,
    input  in_frac,
    input  in_sticky,
    input  in_zero,
    input  in_nar,
    output out_valid,
    input  out_ready,
    output out_posit
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_sign,
    output in_regime,
    output in_exp,
    output in_frac,
    output in_sticky,
    output in_zero,
    output in_nar,
    input  out_valid,
    output out_ready,
    input  out_posit
  );
endinterface

// File: rtl/posit_pack_pipe.sv
// Two-stage posit encoder: stage 1 builds the regime/exp/frac body with guard/sticky and
// saturation, stage 2 rounds to nearest even, applies the sign and encodes zero/NaR.
module posit_pack_pipe #(
  parameter int unsigned BITS   = 32,
  parameter int unsigned ES     = 3,
  parameter int unsigned FRAC_W = 32,
  parameter int unsigned REG_W  = $clog2(BITS) + 2
) (
  input logic               clk,
  input logic               rst,
  posit_pack_pipe_if.slave  bus
);

  localparam int unsigned W       = BITS + FRAC_W + ES + 2;
  localparam int unsigned TailPad = W - ES - FRAC_W;
  localparam int          SatHi   = int'(BITS) - 2;
  localparam int          SatLo   = 1 - int'(BITS);

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic s1_ready, s2_ready, s1_load, s2_load;

  assign s2_ready     = !s2_valid_q || bus.out_ready;
  assign s1_ready     = !s1_valid_q || s2_ready;
  assign bus.in_ready = s1_ready && !rst;
  assign s1_load      = bus.in_valid && bus.in_ready;
  assign s2_load      = s1_valid_q && s2_ready;

  // Stage 1: body construction
  logic signed [REG_W-1:0] k;
  logic                    k_neg;
  logic [REG_W-1:0]        k_mag;
  logic [REG_W:0]          run_len;
  logic [W-1:0]            tail_vec, run_vec, stream_vec;
  logic [BITS-2:0]         s1_body_d, s1_body_q;
  logic                    s1_guard_d, s1_guard_q;
  logic                    s1_sticky_d, s1_sticky_q;
  logic                    s1_sign_q, s1_zero_q, s1_nar_q;

  assign k = $signed(bus.in_regime);

  if (ES > 0) begin : g_exp
    assign tail_vec = {bus.in_exp[ES-1:0], bus.in_frac, {TailPad{1'b0}}};
  end else begin : g_noexp
    assign tail_vec = {bus.in_frac, {TailPad{1'b0}}};
  end

  always_comb begin
    k_neg   = k[REG_W-1];
    k_mag   = k_neg ? -k : k;
    // Run length incl. terminator: k+2 for k >= 0, -k+1 for k < 0
    run_len = {1'b0, k_mag} + {{(REG_W-1){1'b0}}, ~k_neg, k_neg};

    if (k_neg) begin
      run_vec = {1'b1, {(W-1){1'b0}}} >> k_mag;
    end else begin
      run_vec = ~({W{1'b1}} >> (run_len - {{REG_W{1'b0}}, 1'b1}));
    end
    stream_vec = run_vec | (tail_vec >> run_len);

    s1_body_d   = stream_vec[W-1 -: BITS-1];
    s1_guard_d  = stream_vec[W-BITS];
    s1_sticky_d = (|stream_vec[W-BITS-1:0]) | bus.in_sticky;

    if (int'(k) >= SatHi) begin
      s1_body_d   = '1;
      s1_guard_d  = 1'b0;
      s1_sticky_d = 1'b0;
    end else if (int'(k) <= SatLo) begin
      s1_body_d   = {{(BITS-2){1'b0}}, 1'b1};
      s1_guard_d  = 1'b0;
      s1_sticky_d = 1'b0;
    end
  end

  // Stage 2: round, sign, specials
  logic            round_up;
  logic [BITS-2:0] body_rnd;
  logic [BITS-1:0] mag;
  logic [BITS-1:0] out_posit_d, out_posit_q;

  always_comb begin
    // An all-ones body never rounds, so maxpos cannot wrap into NaR
    round_up    = s1_guard_q && (s1_body_q[0] || s1_sticky_q) && !(&s1_body_q);
    body_rnd    = s1_body_q + {{(BITS-2){1'b0}}, round_up};
    mag         = {1'b0, body_rnd};
    out_posit_d = s1_sign_q ? -mag : mag;
    if (s1_zero_q) out_posit_d = '0;
    if (s1_nar_q)  out_posit_d = {1'b1, {(BITS-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_body_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_nar_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_posit_q <= '0;
    end else begin
      if (s1_ready) s1_valid_q <= bus.in_valid;
      if (s1_load) begin
        s1_body_q   <= s1_body_d;
        s1_guard_q  <= s1_guard_d;
        s1_sticky_q <= s1_sticky_d;
        s1_sign_q   <= bus.in_sign;
        s1_zero_q   <= bus.in_zero;
        s1_nar_q    <= bus.in_nar;
      end
      if (s2_ready) s2_valid_q <= s1_valid_q;
      if (s2_load)  out_posit_q <= out_posit_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_posit = out_posit_q;

endmodule

// File: tb/tb_posit_pack_pipe.sv
// Scoreboard bench for posit_pack_pipe at BITS=8, ES=1, FRAC_W=8.
module tb_posit_pack_pipe;
  localparam int unsigned BITS   = 8;
  localparam int unsigned ES     = 1;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned REG_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  posit_pack_pipe_if #(.BITS(BITS), .ES(ES), .FRAC_W(FRAC_W), .REG_W(REG_W)) bus ();

  posit_pack_pipe #(.BITS(BITS), .ES(ES), .FRAC_W(FRAC_W), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_val = 8'h00;
  logic        saw_low = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic s, input int k, input logic e,
                                       input logic [7:0] f, input logic st,
                                       input logic z, input logic nr);
    logic [63:0] v;
    int          p;
    logic [6:0]  body;
    logic        g, sk;
    logic [7:0]  mag;
    if (nr) return 8'h80;
    if (z) return 8'h00;
    g  = 1'b0;
    sk = 1'b0;
    if (k >= 6) begin
      body = 7'h7F;
    end else if (k <= -7) begin
      body = 7'h01;
    end else begin
      v = '0;
      p = 63;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) begin v[p] = 1'b1; p--; end
        v[p] = 1'b0; p--;
      end else begin
        for (int i = 0; i < -k; i++) begin v[p] = 1'b0; p--; end
        v[p] = 1'b1; p--;
      end
      v[p] = e; p--;
      for (int i = 7; i >= 0; i--) begin v[p] = f[i]; p--; end
      body = v[63:57];
      g    = v[56];
      sk   = (|v[55:0]) | st;
    end
    if (g && (body[0] || sk) && body != 7'h7F) body = body + 7'd1;
    mag = {1'b0, body};
    return s ? -mag : mag;
  endfunction

  // Output monitor: hold check while stalled, scoreboard compare on transfer
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (prev_stall) check_eq("stall_hold", bus.out_posit, prev_val);
      if (bus.out_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_out", bus.out_valid, 1'b0);
        else check_eq("result", bus.out_posit, exp_q.pop_front());
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_val   = bus.out_posit;
  end

  task automatic send(input logic s, input int k, input logic e, input logic [7:0] f,
                      input logic st, input logic z, input logic nr, input logic [7:0] expv);
    int waited;
    bus.in_sign   = s;
    bus.in_regime = k[REG_W-1:0];
    bus.in_exp    = e;
    bus.in_frac   = f;
    bus.in_sticky = st;
    bus.in_zero   = z;
    bus.in_nar    = nr;
    bus.in_valid  = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) check_eq("in_ready_timeout", bus.in_ready, 1'b1);
    else exp_q.push_back(expv);
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input logic s, input int k, input logic e, input logic [7:0] f,
                        input logic st, input logic z, input logic nr);
    send(s, k, e, f, st, z, nr, model(s, k, e, f, st, z, nr));
  endtask

  task automatic drain();
    int w;
    bus.in_valid = 1'b0;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_regime = '0;
    bus.in_exp    = '0;
    bus.in_frac   = '0;
    bus.in_sticky = 1'b0;
    bus.in_zero   = 1'b0;
    bus.in_nar    = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_out_posit", bus.out_posit, 8'h00);
    check_eq("rst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Latency on a lone beat
    send(0, 0, 0, 8'h00, 0, 0, 0, 8'h40);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_cycle1", bus.out_valid, 1'b0);
    @(negedge clk);
    check_eq("lat_cycle2", bus.out_valid, 1'b1);
    drain();

    // Directed vectors, back to back
    send(1,  0, 0, 8'h00, 0, 0, 0, 8'hC0);
    send(0, -1, 1, 8'h00, 0, 0, 0, 8'h30);
    send(0,  0, 0, 8'h08, 0, 0, 0, 8'h40);
    send(0,  0, 0, 8'h18, 0, 0, 0, 8'h42);
    send(0,  0, 0, 8'h08, 1, 0, 0, 8'h41);
    send(0,  9, 0, 8'h00, 0, 0, 0, 8'h7F);
    send(0,  6, 0, 8'hFF, 0, 0, 0, 8'h7F);
    send(0, -9, 0, 8'h00, 0, 0, 0, 8'h01);
    send(1, -9, 0, 8'h00, 0, 0, 0, 8'hFF);
    send(1,  3, 1, 8'hA5, 0, 1, 0, 8'h00);
    send(0,  2, 0, 8'h11, 0, 0, 1, 8'h80);
    send(1, -4, 1, 8'h5A, 1, 1, 1, 8'h80);
    drain();

    // Backpressure: out_ready low for cycles 3-6 of a 5-beat stream
    fork
      begin
        for (int i = 0; i < 5; i++) send_m(i[0], i - 2, i[1], 8'h33 * i[7:0], 0, 0, 0);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (!bus.in_ready) saw_low = 1'b1;
          @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
      end
    join
    check_eq("bp_in_ready_low", saw_low, 1'b1);
    drain();

    // Random stream with random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++)
          send_m($urandom_range(0, 1), int'($urandom_range(0, 20)) - 10, $urandom_range(0, 1),
                 8'($urandom), $urandom_range(0, 1), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1 bus.out_ready = $urandom_range(0, 3) != 0;
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Reset with two beats in flight
    bus.out_ready = 1'b0;
    send_m(0, 1, 1, 8'h44, 0, 0, 0);
    send_m(1, 2, 0, 8'h88, 0, 0, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_mid_out_posit", bus.out_posit, 8'h00);
    check_eq("rst_mid_in_ready", bus.in_ready, 1'b0);
    exp_q.delete();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send_m(0, -2, 1, 8'hC0, 0, 0, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_lat1", bus.out_valid, 1'b0);
    @(negedge clk);
    check_eq("post_rst_lat2", bus.out_valid, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
